// File: rtl/execute_pipe.sv
// execute_pipe: two-stage execute stage of the in-order core.
//
// E1 captures an accepted instruction. The single-cycle units compute from
// E1, and E2 registers the selected result set together with its stream tag.
// The optional iterative multiplier starts directly from the accepted
// operands. It holds in_ready low while it steps and loads E2 from its DONE
// state.
//
// Optional feature macro: EXEC_MUL_EN (compiles in the shift-add multiplier).
// Without it, xu_sel=6 retires like the reserved selector and in_ready is 1.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready        : operand-fetch handshake
//   NPC, opA, opB, opC       : next PC, operands, immediate/offset
//   xu_sel, op, tag_in       : unit select, unit-local opcode, stream tag
//   out_valid, result0/1     : one-cycle result set (primary / target or address)
//   we_out, jump_out, tag_out: write enable, branch taken, retiring tag
//   read, write              : memory strobes (read from E1, write from E2)
//   read_address, size       : memory address and access size (0 B, 1 H, 2 W)
//   DATA_in                  : load data, valid while read=1
module execute_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  NPC,
    input  logic [XLEN-1:0]  opA,
    input  logic [XLEN-1:0]  opB,
    input  logic [XLEN-1:0]  opC,
    input  logic [2:0]       xu_sel,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    output logic [XLEN-1:0]  result0,
    output logic [XLEN-1:0]  result1,
    output logic             we_out,
    output logic             jump_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             read,
    output logic             write,
    output logic [XLEN-1:0]  read_address,
    output logic [1:0]       size,
    input  logic [XLEN-1:0]  DATA_in
);

    localparam int SH_W   = $clog2(XLEN);
    localparam int LANE_W = (XLEN > 8) ? $clog2(XLEN / 8) : 1;
    localparam int H_MSB  = (XLEN > 16) ? 15 : XLEN - 1;
    localparam int W_MSB  = (XLEN > 32) ? 31 : XLEN - 1;

    localparam logic [XLEN-1:0] MASK_B = XLEN'(64'h0000_0000_0000_00FF);
    localparam logic [XLEN-1:0] MASK_H = XLEN'(64'h0000_0000_0000_FFFF);
    localparam logic [XLEN-1:0] MASK_W = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [XLEN-1:0] ONE    = XLEN'(1);

    logic accept;
    assign accept = in_valid && in_ready;

    // ---------------- E1 register ----------------
    logic             e1_valid_reg;
    logic [XLEN-1:0]  e1_npc_reg, e1_a_reg, e1_b_reg, e1_c_reg;
    logic [2:0]       e1_sel_reg, e1_op_reg;
    logic [TAG_W-1:0] e1_tag_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e1_valid_reg <= 1'b0;
            e1_npc_reg   <= '0;
            e1_a_reg     <= '0;
            e1_b_reg     <= '0;
            e1_c_reg     <= '0;
            e1_sel_reg   <= '0;
            e1_op_reg    <= '0;
            e1_tag_reg   <= '0;
        end else begin
            e1_valid_reg <= accept;
            if (accept) begin
                e1_npc_reg <= NPC;
                e1_a_reg   <= opA;
                e1_b_reg   <= opB;
                e1_c_reg   <= opC;
                e1_sel_reg <= xu_sel;
                e1_op_reg  <= op;
                e1_tag_reg <= tag_in;
            end
        end
    end

    // One enable per single-cycle unit; a unit whose enable is low sees zeros.
    logic [5:0] unit_en;
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_unit_en
            assign unit_en[gi] = e1_valid_reg && (e1_sel_reg == 3'(gi));
        end
    endgenerate

    // ---------------- adder ----------------
    logic [XLEN-1:0] add_a, add_b, add_res;
    assign add_a = unit_en[1] ? e1_a_reg : '0;
    assign add_b = unit_en[1] ? e1_b_reg : '0;
    always_comb begin
        add_res = '0;
        case (e1_op_reg)
            3'd0: add_res = add_a + add_b;
            3'd1: add_res = add_a - add_b;
            3'd2: add_res = {{(XLEN-1){1'b0}}, $signed(add_a) < $signed(add_b)};
            3'd3: add_res = {{(XLEN-1){1'b0}}, add_a < add_b};
            default: add_res = '0;
        endcase
    end

    // ---------------- logical ----------------
    logic [XLEN-1:0] log_a, log_b, log_res;
    assign log_a = unit_en[2] ? e1_a_reg : '0;
    assign log_b = unit_en[2] ? e1_b_reg : '0;
    always_comb begin
        log_res = '0;
        case (e1_op_reg)
            3'd0: log_res = log_a & log_b;
            3'd1: log_res = log_a | log_b;
            3'd2: log_res = log_a ^ log_b;
            default: log_res = '0;
        endcase
    end

    // ---------------- shifter ----------------
    logic [XLEN-1:0] sh_a, sh_res;
    logic [SH_W-1:0] sh_amt;
    assign sh_a   = unit_en[3] ? e1_a_reg : '0;
    assign sh_amt = unit_en[3] ? e1_b_reg[SH_W-1:0] : '0;
    always_comb begin
        sh_res = '0;
        case (e1_op_reg)
            3'd0: sh_res = sh_a << sh_amt;
            3'd1: sh_res = sh_a >> sh_amt;
            3'd2: sh_res = $unsigned($signed(sh_a) >>> sh_amt);
            default: sh_res = '0;
        endcase
    end

    // ---------------- branch ----------------
    logic [XLEN-1:0] br_a, br_b, br_c, br_npc, br_target;
    logic            br_take;
    assign br_a   = unit_en[4] ? e1_a_reg   : '0;
    assign br_b   = unit_en[4] ? e1_b_reg   : '0;
    assign br_c   = unit_en[4] ? e1_c_reg   : '0;
    assign br_npc = unit_en[4] ? e1_npc_reg : '0;
    // jalr clears bit 0 of the computed target.
    assign br_target = (e1_op_reg == 3'd7) ? ((br_a + br_c) & ~ONE) : (br_npc + br_c);
    always_comb begin
        br_take = 1'b0;
        case (e1_op_reg)
            3'd0: br_take = (br_a == br_b);
            3'd1: br_take = (br_a != br_b);
            3'd2: br_take = ($signed(br_a) < $signed(br_b));
            3'd3: br_take = !($signed(br_a) < $signed(br_b));
            3'd4: br_take = (br_a < br_b);
            3'd5: br_take = !(br_a < br_b);
            default: br_take = 1'b1;
        endcase
    end

    // ---------------- memory ----------------
    logic [XLEN-1:0]   mem_a, mem_b, mem_c, mem_addr;
    logic              is_load;
    logic [LANE_W-1:0] lane;
    logic [XLEN-1:0]   data_sh, ld_mask, ld_data;
    logic              ld_sign;
    logic [1:0]        ld_size, st_size;

    assign mem_a    = unit_en[5] ? e1_a_reg : '0;
    assign mem_b    = unit_en[5] ? e1_b_reg : '0;
    assign mem_c    = unit_en[5] ? e1_c_reg : '0;
    assign mem_addr = mem_a + mem_c;
    assign is_load  = unit_en[5] && (e1_op_reg < 3'd5);

    generate
        if (XLEN > 8) begin : g_lane
            assign lane = mem_addr[LANE_W-1:0];
        end else begin : g_no_lane
            assign lane = 1'b0;
        end
    endgenerate

    // Little-endian: bring the addressed byte lane down to bit 0.
    assign data_sh = DATA_in >> {lane, 3'b000};

    always_comb begin
        ld_mask = MASK_W;
        ld_sign = 1'b0;
        ld_size = 2'd2;
        case (e1_op_reg)
            3'd0: begin ld_mask = MASK_W; ld_sign = data_sh[W_MSB]; ld_size = 2'd2; end
            3'd1: begin ld_mask = MASK_H; ld_sign = data_sh[H_MSB]; ld_size = 2'd1; end
            3'd2: begin ld_mask = MASK_H; ld_sign = 1'b0;           ld_size = 2'd1; end
            3'd3: begin ld_mask = MASK_B; ld_sign = data_sh[7];     ld_size = 2'd0; end
            3'd4: begin ld_mask = MASK_B; ld_sign = 1'b0;           ld_size = 2'd0; end
            default: begin ld_mask = MASK_W; ld_sign = 1'b0;        ld_size = 2'd2; end
        endcase
    end
    assign ld_data = (data_sh & ld_mask) | (~ld_mask & {XLEN{ld_sign}});
    assign st_size = (e1_op_reg == 3'd5) ? 2'd2 : (e1_op_reg == 3'd6) ? 2'd1 : 2'd0;

`ifdef EXEC_MUL_EN
    // ---------------- iterative multiplier ----------------
    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
    mul_state_t        mul_state_reg;
    logic [SH_W-1:0]   mul_cnt_reg;
    logic [XLEN-1:0]   mul_a_reg;
    logic [2*XLEN-1:0] mul_p_reg;
    logic [2:0]        mul_op_reg;
    logic [TAG_W-1:0]  mul_tag_reg;
    logic              mul_start;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_p_next;
    logic [XLEN-1:0]   mul_res;

    assign mul_start = accept && (xu_sel == 3'd6);
    // Product register holds {partial high, remaining multiplier bits}; each
    // step conditionally adds the multiplicand to the high half and shifts right.
    assign mul_sum    = {1'b0, mul_p_reg[2*XLEN-1:XLEN]} + (mul_p_reg[0] ? {1'b0, mul_a_reg} : '0);
    assign mul_p_next = {mul_sum, mul_p_reg[XLEN-1:1]};
    assign mul_res    = (mul_op_reg == 3'd0) ? mul_p_reg[XLEN-1:0] :
                        (mul_op_reg == 3'd1) ? mul_p_reg[2*XLEN-1:XLEN] : '0;
    assign in_ready   = (mul_state_reg != MUL_BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_state_reg <= MUL_IDLE;
            mul_cnt_reg   <= '0;
            mul_a_reg     <= '0;
            mul_p_reg     <= '0;
            mul_op_reg    <= '0;
            mul_tag_reg   <= '0;
        end else begin
            case (mul_state_reg)
                MUL_BUSY: begin
                    mul_p_reg <= mul_p_next;
                    if (mul_cnt_reg == '0) begin
                        mul_state_reg <= MUL_DONE;
                    end else begin
                        mul_cnt_reg <= mul_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new multiply; DONE's result
                    // is read into E2 on this same edge from the old product.
                    if (mul_start) begin
                        mul_state_reg <= MUL_BUSY;
                        mul_cnt_reg   <= SH_W'(XLEN - 1);
                        mul_a_reg     <= opA;
                        mul_p_reg     <= {{XLEN{1'b0}}, opB};
                        mul_op_reg    <= op;
                        mul_tag_reg   <= tag_in;
                    end else begin
                        mul_state_reg <= MUL_IDLE;
                    end
                end
            endcase
        end
    end
`else
    assign in_ready = 1'b1;
`endif

    // ---------------- E2 select ----------------
    logic             out_valid_next, we_next, jump_next, write_next;
    logic [XLEN-1:0]  result0_next, result1_next;
    logic [TAG_W-1:0] tag_next;
    logic [1:0]       size_next;

    always_comb begin
        out_valid_next = 1'b0;
        result0_next   = '0;
        result1_next   = '0;
        we_next        = 1'b0;
        jump_next      = 1'b0;
        write_next     = 1'b0;
        size_next      = 2'd0;
        tag_next       = '0;
        if (e1_valid_reg) begin
            out_valid_next = 1'b1;
            tag_next       = e1_tag_reg;
            case (e1_sel_reg)
                3'd0: begin result0_next = unit_en[0] ? e1_b_reg : '0; we_next = 1'b1; end
                3'd1: begin result0_next = add_res; we_next = 1'b1; end
                3'd2: begin result0_next = log_res; we_next = 1'b1; end
                3'd3: begin result0_next = sh_res;  we_next = 1'b1; end
                3'd4: begin
                    result0_next = br_npc;
                    result1_next = br_target;
                    jump_next    = br_take;
                    we_next      = (e1_op_reg >= 3'd6);
                end
                3'd5: begin
                    result1_next = mem_addr;
                    if (is_load) begin
                        result0_next = ld_data;
                        we_next      = 1'b1;
                    end else begin
                        result0_next = mem_b;
                        write_next   = 1'b1;
                        size_next    = st_size;
                    end
                end
                3'd6: begin
`ifdef EXEC_MUL_EN
                    // The multiplier retires through its DONE state instead.
                    out_valid_next = 1'b0;
                    tag_next       = '0;
`endif
                end
                default: ;
            endcase
        end
`ifdef EXEC_MUL_EN
        // E1 is always a bubble while DONE is present, so no conflict arises.
        if (mul_state_reg == MUL_DONE) begin
            out_valid_next = 1'b1;
            result0_next   = mul_res;
            we_next        = 1'b1;
            tag_next       = mul_tag_reg;
        end
`endif
    end

    // ---------------- E2 register ----------------
    logic             out_valid_reg, we_reg, jump_reg, write_reg;
    logic [XLEN-1:0]  result0_reg, result1_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [1:0]       size_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            result0_reg   <= '0;
            result1_reg   <= '0;
            we_reg        <= 1'b0;
            jump_reg      <= 1'b0;
            write_reg     <= 1'b0;
            size_reg      <= 2'd0;
            tag_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            result0_reg   <= result0_next;
            result1_reg   <= result1_next;
            we_reg        <= we_next;
            jump_reg      <= jump_next;
            write_reg     <= write_next;
            size_reg      <= size_next;
            tag_reg       <= tag_next;
        end
    end

    assign out_valid    = out_valid_reg;
    assign result0      = result0_reg;
    assign result1      = result1_reg;
    assign we_out       = we_reg;
    assign jump_out     = jump_reg;
    assign write        = write_reg;
    assign tag_out      = tag_reg;
    // Loads drive the memory port from E1; stores drive it from E2.
    assign read         = is_load;
    assign read_address = is_load ? mem_addr : (write_reg ? result1_reg : '0);
    assign size         = is_load ? ld_size : size_reg;

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed self-checking bench for execute_pipe (XLEN=32).
// Every comparison goes through the check task; one line per comparison.
module tb_execute_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] NPC, opA, opB, opC;
    logic [2:0]  xu_sel, op;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic [31:0] result0, result1;
    logic        we_out, jump_out;
    logic [3:0]  tag_out;
    logic        read, write;
    logic [31:0] read_address;
    logic [1:0]  size;
    logic [31:0] DATA_in;

    int checks   = 0;
    int failures = 0;

    execute_pipe #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .NPC(NPC), .opA(opA), .opB(opB), .opC(opC),
        .xu_sel(xu_sel), .op(op), .tag_in(tag_in),
        .out_valid(out_valid), .result0(result0), .result1(result1),
        .we_out(we_out), .jump_out(jump_out), .tag_out(tag_out),
        .read(read), .write(write), .read_address(read_address),
        .size(size), .DATA_in(DATA_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    // Present one instruction (or idle) for the next rising edge.
    task automatic drive(input logic v, input logic [2:0] s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] n,
                         input logic [3:0] t);
        @(negedge clk);
        in_valid = v; xu_sel = s; op = o;
        opA = a; opB = b; opC = c; NPC = n; tag_in = t;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int low;
        int seen;
        reset = 1'b0; in_valid = 1'b0; xu_sel = '0; op = '0;
        opA = '0; opB = '0; opC = '0; NPC = '0; tag_in = '0; DATA_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted mid-stream: an in-flight add must vanish.
        drive(1'b1, 3'd1, 3'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result0", result0, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_read", read, 0);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        check("rel_out_valid", out_valid, 0);
        check("rel_flags", {we_out, jump_out, read, write, size}, 0);
        check("rel_results", {result0, result1}, 0);
        check("rel_tag_addr", {tag_out, read_address}, 0);
        check("rel_in_ready", in_ready, 1);

        // add 5+7 tag 3: visible after the second edge, for one cycle.
        drive(1'b1, 3'd1, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3);
        tick();
        check("add_not_yet", out_valid, 0);
        idle();
        tick();
        check("add_valid", out_valid, 1);
        check("add_result0", result0, 12);
        check("add_tag", tag_out, 3);
        check("add_we", we_out, 1);
        tick();
        check("add_one_cycle", out_valid, 0);

        // Back-to-back sub / sra / xor.
        drive(1'b1, 3'd1, 3'd1, 32'd3, 32'd5, 32'd0, 32'd0, 4'd4);
        tick();
        drive(1'b1, 3'd3, 3'd2, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd5);
        tick();
        check("sub_result0", result0, 32'hFFFF_FFFE);
        check("sub_tag", tag_out, 4);
        drive(1'b1, 3'd2, 3'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 4'd6);
        tick();
        check("sra_result0", result0, 32'hF800_0000);
        check("sra_valid", out_valid, 1);
        idle();
        tick();
        check("xor_result0", result0, 32'h0000_0FF0);
        check("xor_tag", tag_out, 6);

        // Branches: bne taken, jalr, beq not taken.
        drive(1'b1, 3'd4, 3'd1, 32'd1, 32'd2, 32'h20, 32'h104, 4'd7);
        tick();
        drive(1'b1, 3'd4, 3'd7, 32'h201, 32'd0, 32'd0, 32'h300, 4'd8);
        tick();
        check("bne_jump", jump_out, 1);
        check("bne_result1", result1, 32'h124);
        check("bne_result0", result0, 32'h104);
        check("bne_we", we_out, 0);
        drive(1'b1, 3'd4, 3'd0, 32'd1, 32'd2, 32'h8, 32'h50, 4'd9);
        tick();
        check("jalr_result1", result1, 32'h200);
        check("jalr_result0", result0, 32'h300);
        check("jalr_we_jump", {we_out, jump_out}, 2'b11);
        idle();
        tick();
        check("beq_nt_jump", jump_out, 0);
        check("beq_nt_result1", result1, 32'h58);

        // lb from 0x1003: read strobe from E1, data sign-extended from lane 3.
        drive(1'b1, 3'd5, 3'd3, 32'h1000, 32'd0, 32'd3, 32'd0, 4'd10);
        tick();
        check("lb_read", read, 1);
        check("lb_addr", read_address, 32'h1003);
        check("lb_size", size, 0);
        DATA_in = 32'h80FF_FFFF;
        drive(1'b1, 3'd5, 3'd2, 32'h1000, 32'd0, 32'd2, 32'd0, 4'd11);
        tick();
        check("lb_result0", result0, 32'hFFFF_FF80);
        check("lb_we_tag", {we_out, tag_out}, {1'b1, 4'd10});
        check("lhu_size", size, 1);
        idle();
        tick();
        check("lhu_result0", result0, 32'h0000_80FF);
        check("lhu_read_drop", read, 0);

        // sh 0xABCD to 0x40.
        drive(1'b1, 3'd5, 3'd6, 32'h40, 32'hABCD, 32'd0, 32'd0, 4'd12);
        tick();
        check("sh_no_early_write", write, 0);
        idle();
        tick();
        check("sh_write", write, 1);
        check("sh_size", size, 1);
        check("sh_result1", result1, 32'h40);
        check("sh_result0", result0, 32'hABCD);
        check("sh_we", we_out, 0);
        tick();
        check("sh_write_drop", write, 0);

        // Reserved selector still retires.
        drive(1'b1, 3'd7, 3'd0, 32'd9, 32'd9, 32'd0, 32'd0, 4'd13);
        tick();
        idle();
        tick();
        check("rsv_valid", out_valid, 1);
        check("rsv_result0_we", {result0, we_out}, 0);

`ifdef EXEC_MUL_EN
        // mulhu 0xFFFFFFFF^2 with an add queued behind it.
        drive(1'b1, 3'd6, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd9);
        tick();
        check("mul_ready_fall", in_ready, 0);
        low = 1;
        drive(1'b1, 3'd1, 3'd0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd10);
        seen = 0;
        while (low < 100) begin
            tick();
            if (out_valid) seen++;
            if (in_ready) break;
            low++;
        end
        check("mul_ready_low_cycles", low, 32);
        check("mul_no_early_out", seen, 0);
        tick();
        check("mul_valid", out_valid, 1);
        check("mul_result0", result0, 32'hFFFF_FFFE);
        check("mul_tag_we", {tag_out, we_out}, {4'd9, 1'b1});
        idle();
        tick();
        check("mul_next_add", {out_valid, result0, tag_out}, {1'b1, 32'd3, 4'd10});

        // Reset during BUSY aborts the multiply.
        drive(1'b1, 3'd6, 3'd0, 32'd6, 32'd7, 32'd0, 32'd0, 4'd2);
        tick();
        idle();
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("mul_abort_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        check("mul_abort_no_out", seen, 0);
`else
        // Without the multiplier, xu_sel=6 retires as reserved.
        drive(1'b1, 3'd6, 3'd0, 32'd3, 32'd4, 32'd0, 32'd0, 4'd2);
        tick();
        check("nomul_ready", in_ready, 1);
        idle();
        tick();
        check("nomul_valid", out_valid, 1);
        check("nomul_result0_we", {result0, we_out}, 0);
        check("nomul_ready_after", in_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Parametrised two-stage execute stage of the in-order core, placed between operand fetch and writeback. Accepts one instruction per cycle through a valid/ready handshake, routes operands to the selected functional unit (adder, logic, shifter, branch, memory, optional iterative multiplier), and registers one result set with its stream tag. The multiplier is the only multi-cycle unit and back-pressures operand fetch while busy.

## Interface
- XLEN, 32, datapath width (power of two, 8..64)
- TAG_W, 4, stream tag width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  operand fetch presents an instruction
- in_ready  out  1  stage can accept; comb = !mul_busy
- NPC, opA, opB, opC  in  XLEN  next PC, operands, immediate/offset
- xu_sel  in  3  0 bypass, 1 adder, 2 logical, 3 shifter, 4 branch, 5 memory, 6 mult, 7 reserved
- op  in  3  unit-local opcode
- tag_in  in  TAG_W  stream tag
- out_valid  out  1  result set valid, one cycle per instruction
- result0, result1  out  XLEN  primary result / secondary (target or store address)
- we_out  out  1  register write enable
- jump_out  out  1  branch taken
- tag_out  out  TAG_W  tag of retiring instruction
- read, write  out  1  memory read/write strobes
- read_address  out  XLEN  load/store address
- size  out  2  0 byte, 1 half, 2 word
- DATA_in  in  XLEN  load data, combinationally valid while read=1

## Operation
- Accept when in_valid && in_ready at edge N; fields captured into E1 register. E1 not loaded otherwise (holds bubble, e1_valid=0).
- Units compute from E1; E2 register loads selected result at edge N+1 (single-cycle units).
- adder: 0 add, 1 sub, 2 slt, 3 sltu; others -> 0. Modulo 2^XLEN, no overflow flag.
- logical: 0 and, 1 or, 2 xor; others -> 0.
- shifter: 0 sll, 1 srl, 2 sra; amount = opB[log2(XLEN)-1:0].
- branch: 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu, 6 jal, 7 jalr. result1 = NPC+opC (jalr: (opA+opC) & ~1). result0 = NPC. jump_out = condition (jal/jalr: 1). we_out = 1 only for jal/jalr.
- memory: op 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5 sw, 6 sh, 7 sb. Address opA+opC; read/read_address driven comb from E1 for loads during cycle N..N+1, DATA_in captured at N+1, sign/zero extended from address-aligned lane (little-endian). Stores: write=1 in E2 cycle, result0 = opB, result1 = address, we_out=0. Misaligned addresses not checked.
- bypass: result0 = opB, we_out=1. Reserved: result0=0, we_out=0, out_valid still 1.
- we_out=1 for adder/logical/shifter/loads/mult; jump_out=0 and write=0 outside branch/store.
- Unselected units see zero operands (no tri-state on internal nets).

## Timing
- Reset: out_valid, we_out, jump_out, read, write, size, result0/1, tag_out, read_address all 0; E1 empty; multiplier IDLE; in_ready=1.
- Single-cycle latency: accept at edge N -> out_valid high in cycle after edge N+1, exactly one cycle; back-to-back issue gives one result per cycle.
- Multiplier FSM: IDLE -> BUSY on accept of xu_sel=6; counter XLEN-1..0, one shift-add step per cycle; BUSY -> DONE at count 0; DONE -> IDLE loads E2. Latency XLEN+1 edges. op 0 mul (low half), 1 mulhu (high half, unsigned); others -> 0.
- in_ready falls the cycle after mult accept, rises the cycle DONE loads E2; next instruction may be accepted on that same edge.
- No output back-pressure: writeback always consumes out_valid.
- reset low mid-multiply aborts; no result emitted.
- in_valid without in_ready: ignored, inputs need not hold.

## Configuration
- EXEC_MUL_EN defined: multiplier and FSM compiled in as above.
- Undefined: xu_sel=6 behaves as reserved (single-cycle, result0=0, we_out=0); in_ready tied 1.

## Test plan
- Reset mid-stream, release -> all outputs 0, in_ready=1, first add 5+7 tag 3 -> out_valid two edges later, result0=12, tag_out=3, we_out=1.
- Back-to-back sub 3-5, sra 0x80000000>>4, xor 0xF0F0^0xFF00 -> consecutive cycles 0xFFFFFFFE, 0xF8000000, 0x0FF0.
- bne opA=1 opB=2 NPC=0x104 opC=0x20 -> jump_out=1, result1=0x124, we_out=0; jalr opA=0x201 opC=0 -> result1=0x200, result0=NPC, we_out=1.
- lb at 0x1003 with DATA_in=0x80FF_FF_FF -> read=1, result0=0xFFFFFF80; sh opB=0xABCD to 0x40 -> write=1, size=1, result1=0x40.
- (EXEC_MUL_EN) mulhu 0xFFFFFFFF*0xFFFFFFFF with add queued -> in_ready low 32 cycles, result0=0xFFFFFFFE, add retires next; reset during BUSY -> no out_valid, in_ready=1.
- Without EXEC_MUL_EN, xu_sel=6 -> result0=0, we_out=0, in_ready never low.
